// File: rtl/mat_mul_pkg.sv
// mat_mul_pkg: state encoding and default sizes shared by the matrix-multiply engine
package mat_mul_pkg;
    localparam int MEM_AW_DEF   = 16;
    localparam int MEM_DW_DEF   = 32;
    localparam int DIM_BITS_DEF = 16;
    localparam int PREC_DEF     = 16;

    typedef enum logic [2:0] {IDLE, RD_A, WAIT_A, RD_B, WAIT_B, MAC, WR_C, DONE} state_e;
endpackage

// File: rtl/mat_mul_mac.sv
// mat_mul_mac: unsigned PREC x PREC multiply-accumulate with synchronous clear, wrapping at DW bits
module mat_mul_mac import mat_mul_pkg::*; #(
    parameter int PREC = PREC_DEF,
    parameter int DW   = MEM_DW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en_i,
    input  logic            clr_i,
    input  logic [PREC-1:0] a_i,
    input  logic [PREC-1:0] b_i,
    output logic [DW-1:0]   acc_o
);
    logic [2*PREC-1:0] prod;
    logic [DW-1:0]     acc_q, acc_d;

    assign prod  = {{PREC{1'b0}}, a_i} * {{PREC{1'b0}}, b_i};
    assign acc_o = acc_q;

    // clear takes priority so a new element never inherits the previous sum
    always_comb acc_d = clr_i ? '0 : en_i ? acc_q + DW'(prod) : acc_q;

    // accumulator register
    always_ff @(posedge clk or posedge rst)
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
endmodule

// File: rtl/mat_mul.sv
// mat_mul: sequential C = A x B engine over a single-port word memory, one read outstanding at a time
module mat_mul import mat_mul_pkg::*; #(
    parameter int MEM_AW   = MEM_AW_DEF,
    parameter int MEM_DW   = MEM_DW_DEF,
    parameter int DIM_BITS = DIM_BITS_DEF,
    parameter int PREC     = PREC_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                go,
    input  logic                sm_ena,
    output logic                ret,
    input  logic [MEM_AW-1:0]   aBASE,
    input  logic [MEM_AW-1:0]   bBASE,
    input  logic [MEM_AW-1:0]   cBASE,
    input  logic [DIM_BITS-1:0] aSTRIDE,
    input  logic [DIM_BITS-1:0] bSTRIDE,
    input  logic [DIM_BITS-1:0] cSTRIDE,
    input  logic [DIM_BITS-1:0] aROWS,
    input  logic [DIM_BITS-1:0] aCOLS,
    input  logic [DIM_BITS-1:0] bCOLS,
    output logic                mem_req,
    output logic                mem_write,
    output logic [MEM_AW-1:0]   mem_addr,
    output logic [MEM_DW-1:0]   mem_wdata,
    input  logic                mem_rdata_vld,
    input  logic [MEM_DW-1:0]   mem_rdata
);
    state_e              state_q, state_d;
    logic [DIM_BITS-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
    logic [DIM_BITS-1:0] i_inc, j_inc, k_inc;
    logic [PREC-1:0]     a_q, a_d, b_q, b_d, hold_data_q, hold_data_d, rd_data;
    logic                hold_vld_q, hold_vld_d, rd_vld;
    logic                mac_en, mac_clr;
    logic [MEM_DW-1:0]   acc;
    logic [MEM_AW-1:0]   addr_a, addr_b, addr_c;
    logic                unused_ok;

    assign unused_ok = ^mem_rdata[MEM_DW-1:PREC];

    assign i_inc = i_q + DIM_BITS'(1);
    assign j_inc = j_q + DIM_BITS'(1);
    assign k_inc = k_q + DIM_BITS'(1);

    assign addr_a = aBASE + MEM_AW'(i_q) * MEM_AW'(aSTRIDE) + MEM_AW'(k_q);
    assign addr_b = bBASE + MEM_AW'(k_q) * MEM_AW'(bSTRIDE) + MEM_AW'(j_q);
    assign addr_c = cBASE + MEM_AW'(i_q) * MEM_AW'(cSTRIDE) + MEM_AW'(j_q);

    // a response that landed during a pause is replayed from the holding register
    assign rd_vld  = hold_vld_q | mem_rdata_vld;
    assign rd_data = hold_vld_q ? hold_data_q : mem_rdata[PREC-1:0];

    assign mem_req   = sm_ena && (state_q == RD_A || state_q == RD_B || state_q == WR_C);
    assign mem_write = state_q == WR_C;
    assign mem_addr  = state_q == RD_A ? addr_a : state_q == RD_B ? addr_b : state_q == WR_C ? addr_c : '0;
    assign mem_wdata = state_q == WR_C ? acc : '0;
    assign ret       = state_q == DONE;

    mat_mul_mac #(.PREC(PREC), .DW(MEM_DW)) u_mac (
        .clk   (clk),
        .rst   (rst),
        .en_i  (mac_en),
        .clr_i (mac_clr),
        .a_i   (a_q),
        .b_i   (b_q),
        .acc_o (acc)
    );

    // next state and loop counters; with sm_ena low only the pause holding register may change
    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        a_d         = a_q;
        b_d         = b_q;
        hold_vld_d  = hold_vld_q;
        hold_data_d = hold_data_q;
        mac_en      = 1'b0;
        mac_clr     = 1'b0;
        if (!sm_ena) begin
            if ((state_q == WAIT_A || state_q == WAIT_B) && mem_rdata_vld && !hold_vld_q) begin
                hold_vld_d  = 1'b1;
                hold_data_d = mem_rdata[PREC-1:0];
            end
        end else begin
            case (state_q)
                IDLE: if (go) begin
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    mac_clr = 1'b1;
                    state_d = (aROWS == '0 || aCOLS == '0 || bCOLS == '0) ? DONE : RD_A;
                end
                RD_A:   state_d = WAIT_A;
                WAIT_A: if (rd_vld) begin
                    a_d        = rd_data;
                    hold_vld_d = 1'b0;
                    state_d    = RD_B;
                end
                RD_B:   state_d = WAIT_B;
                WAIT_B: if (rd_vld) begin
                    b_d        = rd_data;
                    hold_vld_d = 1'b0;
                    state_d    = MAC;
                end
                MAC: begin
                    mac_en  = 1'b1;
                    k_d     = k_inc == aCOLS ? k_q : k_inc;
                    state_d = k_inc == aCOLS ? WR_C : RD_A;
                end
                WR_C: begin
                    mac_clr = 1'b1;
                    k_d     = '0;
                    j_d     = j_inc == bCOLS ? '0 : j_inc;
                    i_d     = j_inc == bCOLS ? i_inc : i_q;
                    state_d = (j_inc == bCOLS && i_inc == aROWS) ? DONE : RD_A;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // state, counters, operand latches and pause holding register
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q     <= IDLE;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            hold_vld_q  <= 1'b0;
            hold_data_q <= '0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            a_q         <= a_d;
            b_q         <= b_d;
            hold_vld_q  <= hold_vld_d;
            hold_data_q <= hold_data_d;
        end
endmodule

// File: tb/tb_mat_mul.sv
// tb_mat_mul: randomized self-checking bench with a request-level reference model of the whole job
module tb_mat_mul;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int DB = 16;

    logic          clk = 1'b0, rst = 1'b1, go = 1'b0, sm_ena = 1'b1;
    logic          ret, mem_req, mem_write;
    logic          mem_rdata_vld = 1'b0;
    logic [AW-1:0] aBASE = '0, bBASE = '0, cBASE = '0, mem_addr;
    logic [DB-1:0] aSTRIDE = '0, bSTRIDE = '0, cSTRIDE = '0, aROWS = '0, aCOLS = '0, bCOLS = '0;
    logic [DW-1:0] mem_wdata, mem_rdata = '0;

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    req_t          exp_q[$];
    req_t          e;
    logic [DW-1:0] mem [0:65535];
    int            n_chk = 0, n_fail = 0, ret_cnt = 0, rd_cnt = 0, pend = 0;
    logic [DW-1:0] pdata;
    bit            rand_pause = 0;
    logic [DW-1:0] c00;
    int            nreq, start;

    mat_mul dut (
        .clk(clk), .rst(rst), .go(go), .sm_ena(sm_ena), .ret(ret),
        .aBASE(aBASE), .bBASE(bBASE), .cBASE(cBASE),
        .aSTRIDE(aSTRIDE), .bSTRIDE(bSTRIDE), .cSTRIDE(cSTRIDE),
        .aROWS(aROWS), .aCOLS(aCOLS), .bCOLS(bCOLS),
        .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata_vld(mem_rdata_vld), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic init_incr();
        for (int a = 0; a < 65536; a++) mem[a] = 32'(a);
    endtask

    task automatic init_rand();
        for (int a = 0; a < 65536; a++) mem[a] = $urandom;
    endtask

    // whole-job model: every request the engine must issue, in order, with the C values
    task automatic build_exp(output logic [DW-1:0] first_c, output int n);
        logic [AW-1:0] aa, ba;
        logic [DW-1:0] sum;
        first_c = '0;
        n = 0;
        if (aROWS == 0 || aCOLS == 0 || bCOLS == 0) return;
        for (int i = 0; i < int'(aROWS); i++)
            for (int j = 0; j < int'(bCOLS); j++) begin
                sum = '0;
                for (int k = 0; k < int'(aCOLS); k++) begin
                    aa = aBASE + 16'(i) * aSTRIDE + 16'(k);
                    ba = bBASE + 16'(k) * bSTRIDE + 16'(j);
                    exp_q.push_back('{1'b0, aa, 32'h0});
                    exp_q.push_back('{1'b0, ba, 32'h0});
                    sum = sum + 32'(mem[aa][15:0]) * 32'(mem[ba][15:0]);
                    n += 2;
                end
                exp_q.push_back('{1'b1, cBASE + 16'(i) * cSTRIDE + 16'(j), sum});
                n++;
                if (i == 0 && j == 0) first_c = sum;
            end
    endtask

    task automatic run_job(input string name, output logic [DW-1:0] first_c, output int n);
        int s;
        build_exp(first_c, n);
        s = ret_cnt;
        @(posedge clk);
        #1 go = 1'b1;
        @(posedge clk);
        while (!sm_ena) @(posedge clk);
        #1 go = 1'b0;
        for (int c = 0; c < 20000 && ret_cnt == s; c++) @(negedge clk);
        chk({name, "_done"}, 64'(ret_cnt != s), 1);
        repeat (4) @(negedge clk);
        chk({name, "_ret_once"}, 64'(ret_cnt - s), 1);
        chk({name, "_all_reqs"}, 64'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    task automatic set_main();
        aBASE = 16'h100; bBASE = 16'h200; cBASE = 16'h300;
        aSTRIDE = 8; bSTRIDE = 8; cSTRIDE = 8;
        aROWS = 6; aCOLS = 4; bCOLS = 5;
    endtask

    // single compare process: every request and every paused cycle against the model
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (!sm_ena) chk("no_req_paused", 64'(mem_req), 0);
            if (mem_req) begin
                if (exp_q.size() == 0) chk("unexpected_req", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("req_write", 64'(mem_write), 64'(e.wr));
                    chk("req_addr", 64'(mem_addr), 64'(e.addr));
                    if (e.wr) chk("req_wdata", 64'(mem_wdata), 64'(e.data));
                end
            end
            if (ret && sm_ena) ret_cnt++;
        end
    end

    // memory responder: random read latency 1..4, writes land immediately
    initial forever begin
        @(negedge clk);
        mem_rdata_vld = 1'b0;
        if (rst) pend = 0;
        else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mem_rdata_vld = 1'b1;
                    mem_rdata     = pdata;
                end
            end
            if (mem_req && !mem_write) begin
                pend  = $urandom_range(1, 4);
                pdata = mem[mem_addr];
                rd_cnt++;
            end
            if (mem_req && mem_write) mem[mem_addr] = mem_wdata;
        end
    end

    // random enable pattern while rand_pause is set
    initial forever begin
        @(posedge clk);
        #1;
        if (rand_pause) sm_ena = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", 64'(mem_req), 0);
        chk("rst_write", 64'(mem_write), 0);
        chk("rst_addr", 64'(mem_addr), 0);
        chk("rst_wdata", 64'(mem_wdata), 0);
        chk("rst_ret", 64'(ret), 0);
        rst = 1'b0;
        repeat (50) begin
            @(negedge clk);
            chk("idle_req", 64'(mem_req), 0);
            chk("idle_ret", 64'(ret), 0);
        end

        init_incr();
        set_main();
        aROWS = 1; aCOLS = 1; bCOLS = 1;
        run_job("one", c00, nreq);
        chk("one_model_c00", 64'(c00), 64'h20000);
        chk("one_model_nreq", 64'(nreq), 3);
        chk("one_mem", 64'(mem[16'h300]), 64'h20000);

        init_incr();
        set_main();
        run_job("main", c00, nreq);
        chk("main_model_c00", 64'(c00), 64'h83C70);
        chk("main_model_nreq", 64'(nreq), 270);
        chk("main_mem_c00", 64'(mem[16'h300]), 64'h83C70);
        for (int i = 0; i < 6; i++)
            for (int j = 5; j < 8; j++) chk("main_untouched", 64'(mem[16'h300 + 8 * i + j]), 64'(16'h300 + 8 * i + j));

        init_incr();
        set_main();
        fork
            run_job("pause", c00, nreq);
            begin
                repeat (40) @(posedge clk);
                #1 sm_ena = 1'b0;
                repeat (20) @(posedge clk);
                #1 sm_ena = 1'b1;
            end
        join
        chk("pause_mem_c00", 64'(mem[16'h300]), 64'h83C70);

        init_incr();
        set_main();
        build_exp(c00, nreq);
        start = rd_cnt;
        @(posedge clk);
        #1 go = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
        for (int c = 0; c < 1000 && rd_cnt < start + 2; c++) @(negedge clk);
        chk("rerst_reached_b", 64'(rd_cnt - start), 2);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rerst_req", 64'(mem_req), 0);
        chk("rerst_write", 64'(mem_write), 0);
        chk("rerst_addr", 64'(mem_addr), 0);
        chk("rerst_wdata", 64'(mem_wdata), 0);
        chk("rerst_ret", 64'(ret), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        init_incr();
        run_job("after_rst", c00, nreq);
        chk("after_rst_mem_c00", 64'(mem[16'h300]), 64'h83C70);

        for (int z = 0; z < 3; z++) begin
            set_main();
            if (z == 0) aCOLS = 0;
            if (z == 1) aROWS = 0;
            if (z == 2) bCOLS = 0;
            build_exp(c00, nreq);
            start = ret_cnt;
            @(posedge clk);
            #1 go = 1'b1;
            @(posedge clk);
            #1 go = 1'b0;
            for (int c = 0; c < 3 && ret_cnt == start; c++) @(negedge clk);
            chk("zero_ret_fast", 64'(ret_cnt - start), 1);
            repeat (5) @(negedge clk);
            chk("zero_ret_once", 64'(ret_cnt - start), 1);
        end

        rand_pause = 1;
        for (int t = 0; t < 10; t++) begin
            init_rand();
            aROWS   = DB'($urandom_range(1, 4));
            aCOLS   = DB'($urandom_range(1, 4));
            bCOLS   = DB'($urandom_range(1, 4));
            aSTRIDE = aCOLS + DB'($urandom_range(0, 3));
            bSTRIDE = bCOLS + DB'($urandom_range(0, 3));
            cSTRIDE = bCOLS + DB'($urandom_range(0, 3));
            aBASE   = t == 0 ? 16'hFFF8 : 16'h1000 + AW'($urandom_range(0, 255));
            bBASE   = 16'h4000 + AW'($urandom_range(0, 255));
            cBASE   = 16'h8000 + AW'($urandom_range(0, 255));
            run_job("rand", c00, nreq);
        end
        rand_pause = 0;
        @(posedge clk);
        @(posedge clk);
        #1 sm_ena = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
